// File: rtl/xillybus_seekmem_if.sv
// xillybus_seekmem_if: user_r/user_w/user_mem signals of one seekable Xillybus stream pair.
// master = Xillybus core side, slave = memory side.
interface xillybus_seekmem_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
);
   logic              user_r_rden;
   logic [DATA_W-1:0] user_r_data;
   logic              user_r_empty;
   logic              user_r_eof;
   logic              user_w_wren;
   logic [DATA_W-1:0] user_w_data;
   logic              user_w_full;
   logic [ADDR_W-1:0] user_mem_addr;
   logic              user_mem_addr_update;

   modport master (
      output user_r_rden, user_w_wren, user_w_data, user_mem_addr, user_mem_addr_update,
      input  user_r_data, user_r_empty, user_r_eof, user_w_full
   );

   modport slave (
      input  user_r_rden, user_w_wren, user_w_data, user_mem_addr, user_mem_addr_update,
      output user_r_data, user_r_empty, user_r_eof, user_w_full
   );
endinterface

// File: rtl/xillybus_seekmem.sv
// xillybus_seekmem: seekable stream memory with clear sequencer and independent read/write pointers.
// Define XILLY_SEEKMEM_EOF_EN to stop pointers at the last word (EOF / full) instead of wrapping.
module xillybus_seekmem #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32
) (
   input  logic                bus_clk,
   input  logic                bus_rst,
   xillybus_seekmem_if.slave   m,
   input  logic                clear_req,
   output logic                busy
);
   if (DEPTH < 2 || DEPTH > 2**ADDR_W) begin : g_bad_depth
      $error("xillybus_seekmem: DEPTH must be in 2..2**ADDR_W");
   end

`ifdef XILLY_SEEKMEM_EOF_EN
   localparam bit EOF_EN = 1'b1;
`else
   localparam bit EOF_EN = 1'b0;
`endif

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] seek;
   logic [DATA_W-1:0] r_data_q, r_data_d;
   logic              eof_q, eof_d, wend_q, wend_d;
   logic              run, rd_acc, wr_acc, enter_clear, flush;
   logic              rd_last, wr_last;

   always_comb begin
      run         = state_q == RUN;
      rd_acc      = run & m.user_r_rden & ~eof_q;
      wr_acc      = run & m.user_w_wren & ~wend_q;
      rd_last     = rd_ptr_q == LAST;
      wr_last     = wr_ptr_q == LAST;
      enter_clear = run & clear_req;
      flush       = m.user_mem_addr_update | enter_clear;
      seek        = ({1'b0, m.user_mem_addr} < (ADDR_W+1)'(DEPTH)) ? m.user_mem_addr : '0;
      state_d     = (!run && clr_ptr_q == LAST) ? RUN : enter_clear ? CLEAR : state_q;
      clr_ptr_d   = (run || clr_ptr_q == LAST) ? '0 : clr_ptr_q + 1'b1;
      // A seek wins over a same-cycle increment; the access itself still used the old pointer.
      rd_ptr_d    = m.user_mem_addr_update ? seek :
                    (rd_acc && !(EOF_EN && rd_last)) ? (rd_last ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
      wr_ptr_d    = m.user_mem_addr_update ? seek :
                    (wr_acc && !(EOF_EN && wr_last)) ? (wr_last ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
      eof_d       = flush ? 1'b0 : eof_q  | (EOF_EN & rd_acc & rd_last);
      wend_d      = flush ? 1'b0 : wend_q | (EOF_EN & wr_acc & wr_last);
      r_data_d    = rd_acc ? mem[rd_ptr_q] : r_data_q;
   end

   always_ff @(posedge bus_clk) begin
      if (bus_rst) begin
         state_q   <= CLEAR;
         clr_ptr_q <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         r_data_q  <= '0;
         eof_q     <= 1'b0;
         wend_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         r_data_q  <= r_data_d;
         eof_q     <= eof_d;
         wend_q    <= wend_d;
      end
   end

   // Single write port shared by the clear sequencer and the stream writer.
   always_ff @(posedge bus_clk) begin
      if (!bus_rst && !run)
         mem[clr_ptr_q] <= '0;
      else if (!bus_rst && wr_acc)
         mem[wr_ptr_q] <= m.user_w_data;
   end

   assign busy           = ~run;
   assign m.user_r_data  = r_data_q;
   assign m.user_r_empty = ~run | eof_q;
   assign m.user_w_full  = ~run | wend_q;
   assign m.user_r_eof   = eof_q;
endmodule

// File: tb/tb_xillybus_seekmem.sv
// tb_xillybus_seekmem: directed table-driven check of the seekable memory (DATA_W=16, DEPTH=24).
module tb_xillybus_seekmem;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clear_req = 1'b0;
   logic busy;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   xillybus_seekmem_if #(.DATA_W(16), .ADDR_W(5)) bus ();

   xillybus_seekmem #(.DATA_W(16), .ADDR_W(5), .DEPTH(24)) dut (
      .bus_clk   (clk),
      .bus_rst   (rst),
      .m         (bus.slave),
      .clear_req (clear_req),
      .busy      (busy)
   );

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic        up;
      logic [4:0]  addr;
      logic [15:0] wd;
      logic [15:0] rdat;
   } vec_t;

   vec_t tv [21];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic rd, input logic wr, input logic up,
                       input logic [4:0] addr, input logic [15:0] wd);
      bus.user_r_rden          = rd;
      bus.user_w_wren          = wr;
      bus.user_mem_addr_update = up;
      bus.user_mem_addr        = addr;
      bus.user_w_data          = wd;
      cyc();
      bus.user_r_rden          = 1'b0;
      bus.user_w_wren          = 1'b0;
      bus.user_mem_addr_update = 1'b0;
   endtask

   task automatic flags(input string nm, input logic b, input logic e, input logic f);
      chk({nm, ".busy"}, busy, b);
      chk({nm, ".empty"}, bus.user_r_empty, e);
      chk({nm, ".full"}, bus.user_w_full, f);
   endtask

   // Holds reset two cycles, then expects exactly 24 busy cycles.
   task automatic reset_and_clear();
      rst = 1'b1;
      cyc();
      flags("rst", 1'b1, 1'b1, 1'b1);
      chk("rst.rdata", bus.user_r_data, 16'h0);
      chk("rst.eof", bus.user_r_eof, 1'b0);
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 24; i++) begin
         flags($sformatf("clr%0d", i), 1'b1, 1'b1, 1'b1);
         cyc();
      end
      flags("clr_done", 1'b0, 1'b0, 1'b0);
   endtask

   task automatic read_zeros();
      step(1'b0, 1'b0, 1'b1, 5'd0, 16'h0);
      for (int i = 0; i < 24; i++) begin
         step(1'b1, 1'b0, 1'b0, 5'd0, 16'h0);
         chk($sformatf("zero[%0d]", i), bus.user_r_data, 16'h0);
      end
   endtask

   initial begin
      //                 rd    wr    up    addr   wd        rdat
      tv[0]  = '{1'b0, 1'b0, 1'b1, 5'd3,  16'h0,    16'h0000};
      tv[1]  = '{1'b0, 1'b1, 1'b0, 5'd0,  16'hA1B2, 16'h0000};
      tv[2]  = '{1'b0, 1'b1, 1'b0, 5'd0,  16'hC3D4, 16'h0000};
      tv[3]  = '{1'b0, 1'b0, 1'b1, 5'd3,  16'h0,    16'h0000};
      tv[4]  = '{1'b1, 1'b0, 1'b0, 5'd0,  16'h0,    16'hA1B2};
      tv[5]  = '{1'b1, 1'b0, 1'b0, 5'd0,  16'h0,    16'hC3D4};
      tv[6]  = '{1'b0, 1'b0, 1'b0, 5'd0,  16'h0,    16'hC3D4};
      tv[7]  = '{1'b0, 1'b1, 1'b1, 5'd30, 16'h5555, 16'hC3D4};
      tv[8]  = '{1'b1, 1'b0, 1'b0, 5'd0,  16'h0,    16'h0000};
      tv[9]  = '{1'b0, 1'b0, 1'b1, 5'd3,  16'h0,    16'h0000};
      tv[10] = '{1'b1, 1'b0, 1'b0, 5'd0,  16'h0,    16'h5555};
      tv[11] = '{1'b1, 1'b0, 1'b1, 5'd3,  16'h0,    16'hC3D4};
      tv[12] = '{1'b1, 1'b0, 1'b0, 5'd0,  16'h0,    16'h5555};
      tv[13] = '{1'b0, 1'b0, 1'b1, 5'd10, 16'h0,    16'h5555};
      tv[14] = '{1'b1, 1'b1, 1'b0, 5'd0,  16'h1234, 16'h0000};
      tv[15] = '{1'b0, 1'b0, 1'b1, 5'd10, 16'h0,    16'h0000};
      tv[16] = '{1'b1, 1'b0, 1'b0, 5'd0,  16'h0,    16'h1234};
      tv[17] = '{1'b0, 1'b1, 1'b0, 5'd0,  16'h0F0F, 16'h1234};
      tv[18] = '{1'b1, 1'b0, 1'b0, 5'd0,  16'h0,    16'h0000};
      tv[19] = '{1'b0, 1'b0, 1'b1, 5'd10, 16'h0,    16'h0000};
      tv[20] = '{1'b1, 1'b0, 1'b0, 5'd0,  16'h0,    16'h0F0F};

      bus.user_r_rden = 1'b0;
      bus.user_w_wren = 1'b0;
      bus.user_w_data = '0;
      bus.user_mem_addr = '0;
      bus.user_mem_addr_update = 1'b0;

      reset_and_clear();
      read_zeros();

      for (int i = 0; i < 21; i++) begin
         step(tv[i].rd, tv[i].wr, tv[i].up, tv[i].addr, tv[i].wd);
         chk($sformatf("vec%0d.rdata", i), bus.user_r_data, tv[i].rdat);
         flags($sformatf("vec%0d", i), 1'b0, 1'b0, 1'b0);
      end

      // Write across the end of memory.
      step(1'b0, 1'b0, 1'b1, 5'd22, 16'h0);
      step(1'b0, 1'b1, 1'b0, 5'd0, 16'd1);
      step(1'b0, 1'b1, 1'b0, 5'd0, 16'd2);
`ifdef XILLY_SEEKMEM_EOF_EN
      chk("wend.full", bus.user_w_full, 1'b1);
      step(1'b0, 1'b1, 1'b0, 5'd0, 16'd3);
      step(1'b0, 1'b1, 1'b0, 5'd0, 16'd4);
      chk("wend.full2", bus.user_w_full, 1'b1);
      step(1'b0, 1'b0, 1'b1, 5'd22, 16'h0);
      chk("wend.seekclr", bus.user_w_full, 1'b0);
      step(1'b1, 1'b0, 1'b0, 5'd0, 16'h0);
      chk("wrap.r22", bus.user_r_data, 16'd1);
      step(1'b1, 1'b0, 1'b0, 5'd0, 16'h0);
      chk("wrap.r23", bus.user_r_data, 16'd2);
      step(1'b0, 1'b0, 1'b1, 5'd0, 16'h0);
      step(1'b1, 1'b0, 1'b0, 5'd0, 16'h0);
      chk("wrap.r0", bus.user_r_data, 16'h0);
`else
      step(1'b0, 1'b1, 1'b0, 5'd0, 16'd3);
      step(1'b0, 1'b1, 1'b0, 5'd0, 16'd4);
      chk("wrap.full", bus.user_w_full, 1'b0);
      step(1'b0, 1'b0, 1'b1, 5'd22, 16'h0);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 1'b0, 5'd0, 16'h0);
         chk($sformatf("wrap.r%0d", i), bus.user_r_data, 16'(i + 1));
      end
`endif

      // Read the last word, then once more.
      step(1'b0, 1'b0, 1'b1, 5'd23, 16'h0);
      step(1'b1, 1'b0, 1'b0, 5'd0, 16'h0);
      chk("eof.r23", bus.user_r_data, 16'd2);
`ifdef XILLY_SEEKMEM_EOF_EN
      chk("eof.flag", bus.user_r_eof, 1'b1);
      chk("eof.empty", bus.user_r_empty, 1'b1);
      step(1'b1, 1'b0, 1'b0, 5'd0, 16'h0);
      chk("eof.hold", bus.user_r_data, 16'd2);
      chk("eof.flag2", bus.user_r_eof, 1'b1);
      step(1'b0, 1'b0, 1'b1, 5'd0, 16'h0);
      chk("eof.seekclr", bus.user_r_eof, 1'b0);
      chk("eof.empty2", bus.user_r_empty, 1'b0);
`else
      chk("eof.flag", bus.user_r_eof, 1'b0);
      chk("eof.empty", bus.user_r_empty, 1'b0);
      step(1'b1, 1'b0, 1'b0, 5'd0, 16'h0);
      chk("eof.wrap", bus.user_r_data, 16'd3);
`endif

      // clear_req during CLEAR must not restart the sequence.
      clear_req = 1'b1;
      cyc();
      clear_req = 1'b0;
      for (int k = 1; k <= 24; k++) begin
         chk($sformatf("creq%0d.busy", k), busy, 1'b1);
         clear_req = (k == 5);
         cyc();
      end
      clear_req = 1'b0;
      flags("creq_done", 1'b0, 1'b0, 1'b0);
      chk("creq.eof", bus.user_r_eof, 1'b0);

      // Write data again, then clear interrupted by reset.
      step(1'b0, 1'b0, 1'b1, 5'd5, 16'h0);
      step(1'b0, 1'b1, 1'b0, 5'd0, 16'hDEAD);
      clear_req = 1'b1;
      cyc();
      clear_req = 1'b0;
      for (int k = 1; k < 10; k++) begin
         chk($sformatf("crst%0d.busy", k), busy, 1'b1);
         clear_req = (k == 5);
         cyc();
      end
      clear_req = 1'b0;
      reset_and_clear();
      read_zeros();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
